// File: rtl/matrix_addr_seq_if.sv
// Handshake and status bundle between the matrix control registers and the address sequencer.
interface matrix_addr_seq_if #(
    parameter int ADDR_MSB = 11,
    parameter int DIM_MSB  = 5,
    parameter int BANKS    = 2
);
    localparam int BANK_W = $clog2(BANKS);

    logic                we;
    logic                re;
    logic                transpose;
    logic [DIM_MSB:0]    max_row_count;
    logic [DIM_MSB:0]    max_col_count;
    logic [ADDR_MSB:0]   wr_a;
    logic [BANK_W-1:0]   wr_bank;
    logic [ADDR_MSB:0]   rd_a;
    logic [BANK_W-1:0]   rd_bank;
    logic                full;
    logic                empty;
    logic                wr_done;
    logic                rd_done;
    logic                err;

    modport master (
        output we, re, transpose, max_row_count, max_col_count,
        input  wr_a, wr_bank, rd_a, rd_bank, full, empty, wr_done, rd_done, err
    );

    modport slave (
        input  we, re, transpose, max_row_count, max_col_count,
        output wr_a, wr_bank, rd_a, rd_bank, full, empty, wr_done, rd_done, err
    );
endinterface

// File: rtl/matrix_addr_seq.sv
// Multi-bank matrix address sequencer: independent write/read address walks over BANKS
// ping-pong buffers, with row-major or column-major reads and occupancy tracking.
module matrix_addr_seq #(
    parameter int ADDR_MSB = 11,
    parameter int DIM_MSB  = 5,
    parameter int BANKS    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    matrix_addr_seq_if.slave  bus
);
    localparam int BANK_W = $clog2(BANKS);
    localparam int FILL_W = $clog2(BANKS + 1);

    typedef logic [ADDR_MSB:0] addr_t;
    typedef logic [DIM_MSB:0]  dim_t;
    typedef logic [BANK_W-1:0] bank_t;
    typedef logic [FILL_W-1:0] fill_t;

    // One pass walker; base is the address at the top of the current column (transposed walk).
    typedef struct packed {
        dim_t  row;
        dim_t  col;
        dim_t  max_row;
        dim_t  max_col;
        logic  tr;
        addr_t addr;
        addr_t base;
        bank_t bank;
    } cnt_t;

    // The first beat of a pass sees live configuration; later beats use the shadows.
    function automatic logic is_first(input cnt_t s);
        return (s.row == '0) && (s.col == '0);
    endfunction

    function automatic logic is_last(input cnt_t s, input dim_t live_row, input dim_t live_col);
        dim_t mr;
        dim_t mc;
        mr = is_first(s) ? live_row : s.max_row;
        mc = is_first(s) ? live_col : s.max_col;
        return (s.row == mr) && (s.col == mc);
    endfunction

    function automatic cnt_t advance(input cnt_t s, input dim_t live_row, input dim_t live_col,
                                     input logic live_tr);
        cnt_t n;
        dim_t mr;
        dim_t mc;
        logic tr;
        n  = s;
        mr = is_first(s) ? live_row : s.max_row;
        mc = is_first(s) ? live_col : s.max_col;
        tr = is_first(s) ? live_tr  : s.tr;
        n.max_row = mr;
        n.max_col = mc;
        n.tr      = tr;
        if ((s.row == mr) && (s.col == mc)) begin
            n.row  = '0;
            n.col  = '0;
            n.addr = '0;
            n.base = '0;
            n.bank = (s.bank == bank_t'(BANKS - 1)) ? '0 : s.bank + 1'b1;
        end else if (!tr) begin
            if (s.col == mc) begin
                n.col = '0;
                n.row = s.row + 1'b1;
            end else begin
                n.col = s.col + 1'b1;
            end
            n.addr = s.addr + 1'b1;
        end else begin
            if (s.row == mr) begin
                n.row  = '0;
                n.col  = s.col + 1'b1;
                n.base = s.base + 1'b1;
                n.addr = s.base + 1'b1;
            end else begin
                n.row  = s.row + 1'b1;
                n.addr = s.addr + addr_t'(mc) + 1'b1;
            end
        end
        return n;
    endfunction

    cnt_t  wr_q, wr_d;
    cnt_t  rd_q, rd_d;
    fill_t fill_q, fill_d;
    logic  full_q, empty_q;
    logic  wr_done_q, rd_done_q, err_q;
    logic  wr_ok, rd_ok, wr_end, rd_end;

    // Refusal is decided from registered status only, never from a pass ending this cycle.
    assign wr_ok  = bus.we && !full_q;
    assign rd_ok  = bus.re && !empty_q;
    assign wr_end = wr_ok && is_last(wr_q, bus.max_row_count, bus.max_col_count);
    assign rd_end = rd_ok && is_last(rd_q, bus.max_row_count, bus.max_col_count);

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        wr_d   = advance(wr_q, bus.max_row_count, bus.max_col_count, 1'b0);
        rd_d   = advance(rd_q, bus.max_row_count, bus.max_col_count, bus.transpose);
        fill_d = fill_q;
        case ({wr_end, rd_end})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q      <= '0;
            rd_q      <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (wr_ok) wr_q <= wr_d;
            if (rd_ok) rd_q <= rd_d;
            fill_q    <= fill_d;
            full_q    <= (fill_d == fill_t'(BANKS));
            empty_q   <= (fill_d == '0);
            wr_done_q <= wr_end;
            rd_done_q <= rd_end;
            err_q     <= err_q | (bus.we && full_q) | (bus.re && empty_q);
        end
    end

    assign bus.wr_a    = wr_q.addr;
    assign bus.wr_bank = wr_q.bank;
    assign bus.rd_a    = rd_q.addr;
    assign bus.rd_bank = rd_q.bank;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.wr_done = wr_done_q;
    assign bus.rd_done = rd_done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_matrix_addr_seq.sv
// Directed bench for matrix_addr_seq: expected addresses queued at stimulus time, popped per beat.
module tb_matrix_addr_seq;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   exp_wr[$];
    int   exp_rd[$];

    always #5 CLK = ~CLK;

    matrix_addr_seq_if #(.ADDR_MSB(11), .DIM_MSB(5), .BANKS(2)) bus ();

    matrix_addr_seq #(.ADDR_MSB(11), .DIM_MSB(5), .BANKS(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge and compare the addresses presented for its beats.
    task automatic step(input logic w, input logic r);
        @(negedge CLK);
        bus.we = w;
        bus.re = r;
        if (w) begin
            if (exp_wr.size() == 0) check("wr_queue_empty", 32'd1, 32'd0);
            else check("wr_a", 32'(bus.wr_a), 32'(exp_wr.pop_front()));
        end
        if (r) begin
            if (exp_rd.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
            else check("rd_a", 32'(bus.rd_a), 32'(exp_rd.pop_front()));
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wr_a"},    32'(bus.wr_a),    32'd0);
        check({tag, "_rd_a"},    32'(bus.rd_a),    32'd0);
        check({tag, "_wr_bank"}, 32'(bus.wr_bank), 32'd0);
        check({tag, "_rd_bank"}, 32'(bus.rd_bank), 32'd0);
        check({tag, "_full"},    32'(bus.full),    32'd0);
        check({tag, "_empty"},   32'(bus.empty),   32'd1);
        check({tag, "_wr_done"}, 32'(bus.wr_done), 32'd0);
        check({tag, "_rd_done"}, 32'(bus.rd_done), 32'd0);
        check({tag, "_err"},     32'(bus.err),     32'd0);
    endtask

    initial begin
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.transpose = 1'b0;
        bus.max_row_count = 6'd1;
        bus.max_col_count = 6'd2;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_reset_state("reset");

        // Read while empty is refused and flagged.
        exp_rd.push_back(0);
        step(1'b0, 1'b1);
        idle();
        check("re_empty_err",   32'(bus.err),   32'd1);
        check("re_empty_rd_a",  32'(bus.rd_a),  32'd0);
        check("re_empty_empty", 32'(bus.empty), 32'd1);
        do_reset();
        check("err_cleared", 32'(bus.err), 32'd0);

        // 2x3 write pass, row-major.
        for (int i = 0; i < 6; i++) exp_wr.push_back(i);
        repeat (6) step(1'b1, 1'b0);
        idle();
        check("w1_wr_done", 32'(bus.wr_done), 32'd1);
        check("w1_wr_bank", 32'(bus.wr_bank), 32'd1);
        check("w1_empty",   32'(bus.empty),   32'd0);
        check("w1_full",    32'(bus.full),    32'd0);
        idle();
        check("w1_done_pulse", 32'(bus.wr_done), 32'd0);

        // Transposed read of the 2x3 matrix.
        bus.transpose = 1'b1;
        exp_rd.push_back(0); exp_rd.push_back(3); exp_rd.push_back(1);
        exp_rd.push_back(4); exp_rd.push_back(2); exp_rd.push_back(5);
        repeat (6) step(1'b0, 1'b1);
        idle();
        check("r1_rd_done", 32'(bus.rd_done), 32'd1);
        check("r1_rd_bank", 32'(bus.rd_bank), 32'd1);
        check("r1_empty",   32'(bus.empty),   32'd1);
        check("r1_err",     32'(bus.err),     32'd0);
        do_reset();

        // Column count changes after beat 2; this pass keeps cols=3, the next uses cols=4.
        bus.transpose = 1'b0;
        bus.max_col_count = 6'd2;
        for (int i = 0; i < 6; i++) exp_wr.push_back(i);
        repeat (2) step(1'b1, 1'b0);
        bus.max_col_count = 6'd3;
        repeat (4) step(1'b1, 1'b0);
        idle();
        check("cfg_wr_done", 32'(bus.wr_done), 32'd1);
        check("cfg_wr_bank", 32'(bus.wr_bank), 32'd1);
        for (int i = 0; i < 8; i++) exp_wr.push_back(i);
        repeat (8) step(1'b1, 1'b0);
        idle();
        check("cfg2_wr_done", 32'(bus.wr_done), 32'd1);
        check("cfg2_wr_bank", 32'(bus.wr_bank), 32'd0);
        check("full_set",     32'(bus.full),    32'd1);

        // Write while full is refused and the error sticks.
        exp_wr.push_back(0);
        step(1'b1, 1'b0);
        idle();
        check("refuse_wr_a",    32'(bus.wr_a),    32'd0);
        check("refuse_wr_bank", 32'(bus.wr_bank), 32'd0);
        check("refuse_err",     32'(bus.err),     32'd1);
        check("refuse_done",    32'(bus.wr_done), 32'd0);
        repeat (3) idle();
        check("err_sticky", 32'(bus.err), 32'd1);

        // Row-major read of bank 0 with live 2x4 configuration.
        for (int i = 0; i < 8; i++) exp_rd.push_back(i);
        repeat (8) step(1'b0, 1'b1);
        idle();
        check("r2_rd_done", 32'(bus.rd_done), 32'd1);
        check("r2_rd_bank", 32'(bus.rd_bank), 32'd1);
        check("r2_full",    32'(bus.full),    32'd0);
        check("r2_empty",   32'(bus.empty),   32'd0);

        // Concurrent: transposed read of bank 1 with write of bank 0, ending together.
        bus.transpose = 1'b1;
        for (int i = 0; i < 8; i++) exp_wr.push_back(i);
        exp_rd.push_back(0); exp_rd.push_back(4); exp_rd.push_back(1); exp_rd.push_back(5);
        exp_rd.push_back(2); exp_rd.push_back(6); exp_rd.push_back(3); exp_rd.push_back(7);
        repeat (8) step(1'b1, 1'b1);
        idle();
        check("cc_wr_done", 32'(bus.wr_done), 32'd1);
        check("cc_rd_done", 32'(bus.rd_done), 32'd1);
        check("cc_full",    32'(bus.full),    32'd0);
        check("cc_empty",   32'(bus.empty),   32'd0);
        check("cc_wr_bank", 32'(bus.wr_bank), 32'd1);
        check("cc_rd_bank", 32'(bus.rd_bank), 32'd0);
        check("cc_err",     32'(bus.err),     32'd1);

        // Reset asserted during beat 3 of a write pass.
        do_reset();
        bus.transpose = 1'b0;
        bus.max_col_count = 6'd2;
        exp_wr.push_back(0); exp_wr.push_back(1);
        repeat (2) step(1'b1, 1'b0);
        @(negedge CLK);
        bus.we = 1'b1;
        RST = 1'b1;
        check("mid_beat3_wr_a", 32'(bus.wr_a), 32'd2);
        @(negedge CLK);
        RST = 1'b0;
        bus.we = 1'b0;
        check_reset_state("mid_rst");
        for (int i = 0; i < 6; i++) exp_wr.push_back(i);
        repeat (6) step(1'b1, 1'b0);
        idle();
        check("post_rst_wr_done", 32'(bus.wr_done), 32'd1);
        check("post_rst_wr_bank", 32'(bus.wr_bank), 32'd1);
        check("post_rst_empty",   32'(bus.empty),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
